// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the MIPS core: payload + valid + feedback
// sideband, driven by the core stall vector, with flush and saturating event counters.
module pipe_stage_reg #(
    parameter int                DATA_W   = 32,
    parameter int                FB_W     = 1,
    parameter int                STALL_W  = 6,
    parameter int                STAGE    = 2,
    parameter logic [DATA_W-1:0] NOP_DATA = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic [FB_W-1:0]    in_fb,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [FB_W-1:0]    out_fb,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } act_e;

    act_e               act;
    logic               s_up;
    logic               s_dn;
    logic               unused_stall;

    logic [DATA_W-1:0]  data_q,   data_d;
    logic               valid_q,  valid_d;
    logic [FB_W-1:0]    fb_q,     fb_d;
    logic [CNT_W-1:0]   hold_q,   hold_d;
    logic [CNT_W-1:0]   bubble_q, bubble_d;
    logic [CNT_W-1:0]   flush_q,  flush_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign s_up         = stall[STAGE];
    assign s_dn         = stall[STAGE+1];
    assign unused_stall = ^stall;

    // Illegal vector (s_up=0, s_dn=1) deliberately falls through to LOAD.
    always_comb begin
        act = ACT_LOAD;
        if (flush)
            act = ACT_FLUSH;
        else if (s_up && !s_dn)
            act = ACT_BUBBLE;
        else if (s_up && s_dn)
            act = ACT_HOLD;
    end

    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        fb_d     = fb_q;
        hold_d   = hold_q;
        bubble_d = bubble_q;
        flush_d  = flush_q;
        case (act)
            ACT_FLUSH: begin
                data_d  = NOP_DATA;
                valid_d = 1'b0;
                fb_d    = '0;
                flush_d = sat_inc(flush_q);
            end
            ACT_BUBBLE: begin
                data_d   = NOP_DATA;
                valid_d  = 1'b0;
                fb_d     = '0;
                bubble_d = sat_inc(bubble_q);
            end
            ACT_HOLD: begin
                hold_d = sat_inc(hold_q);
            end
            default: begin
                data_d  = in_data;
                valid_d = in_valid;
                fb_d    = in_fb;
            end
        endcase
        // Clear wins over any increment taken on the same edge.
        if (cnt_clr) begin
            hold_d   = '0;
            bubble_d = '0;
            flush_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= NOP_DATA;
            valid_q  <= 1'b0;
            fb_q     <= '0;
            hold_q   <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            fb_q     <= fb_d;
            hold_q   <= hold_d;
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_fb     = fb_q;
    assign hold_cnt   = hold_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table plus hand-written reset and
// combinational-isolation sequences. Small counters make saturation reachable.
module tb_pipe_stage_reg;

    localparam int DATA_W  = 32;
    localparam int FB_W    = 2;
    localparam int STALL_W = 6;
    localparam int CNT_W   = 3;

    logic               clk;
    logic               rst;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic [FB_W-1:0]    in_fb;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               cnt_clr;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic [FB_W-1:0]    out_fb;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   bubble_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .FB_W    (FB_W),
        .STALL_W (STALL_W),
        .STAGE   (2),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_fb      (in_fb),
        .stall      (stall),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_fb     (out_fb),
        .hold_cnt   (hold_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [5:0]  stall;
        logic [31:0] d;
        logic        v;
        logic [1:0]  fb;
        logic        clr;
        logic [31:0] ed;
        logic        ev;
        logic [1:0]  efb;
        int          eh;
        int          eb;
        int          ef;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_HOLD = 6'b001100;
    localparam logic [5:0] S_BUB  = 6'b000100;
    localparam logic [5:0] S_ILL  = 6'b001000;

    task automatic addv(input logic f, input logic [5:0] s, input logic [31:0] d,
                        input logic v, input logic [1:0] fb, input logic clr,
                        input logic [31:0] ed, input logic ev, input logic [1:0] efb,
                        input int eh, input int eb, input int ef);
        vec_t t;
        t.flush = f;  t.stall = s; t.d = d;   t.v = v;   t.fb = fb;   t.clr = clr;
        t.ed = ed;    t.ev = ev;   t.efb = efb; t.eh = eh; t.eb = eb; t.ef = ef;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ed, input logic ev,
                             input logic [1:0] efb, input int eh, input int eb, input int ef);
        check({tag, ".data"},   64'(out_data),   64'(ed));
        check({tag, ".valid"},  64'(out_valid),  64'(ev));
        check({tag, ".fb"},     64'(out_fb),     64'(efb));
        check({tag, ".hold"},   64'(hold_cnt),   64'(eh));
        check({tag, ".bubble"}, 64'(bubble_cnt), 64'(eb));
        check({tag, ".flush"},  64'(flush_cnt),  64'(ef));
    endtask

    function automatic int sat7(input int n);
        return (n > 7) ? 7 : n;
    endfunction

    initial begin
        // Load stream, hold, bubble, flush priority, illegal vector, other stall bits
        addv(0, S_NONE, 32'h1,  1, 2'd1, 0, 32'h1,  1, 2'd1, 0, 0, 0);
        addv(0, S_NONE, 32'h2,  1, 2'd2, 0, 32'h2,  1, 2'd2, 0, 0, 0);
        addv(0, S_NONE, 32'h3,  0, 2'd3, 0, 32'h3,  0, 2'd3, 0, 0, 0);
        addv(0, S_NONE, 32'h4,  1, 2'd0, 0, 32'h4,  1, 2'd0, 0, 0, 0);
        addv(0, S_NONE, 32'hA5, 1, 2'd1, 0, 32'hA5, 1, 2'd1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            addv(0, S_HOLD, 32'h77, 1, 2'd2, 0, 32'hA5, 1, 2'd1, i + 1, 0, 0);
        addv(0, S_NONE, 32'h77, 1, 2'd2, 0, 32'h77, 1, 2'd2, 3, 0, 0);
        addv(0, S_NONE, 32'h11, 1, 2'd3, 0, 32'h11, 1, 2'd3, 3, 0, 0);
        for (int i = 0; i < 2; i++)
            addv(0, S_BUB, 32'h22, 1, 2'd1, 0, 32'h0, 0, 2'd0, 3, i + 1, 0);
        addv(0, S_NONE, 32'h22, 1, 2'd1, 0, 32'h22, 1, 2'd1, 3, 2, 0);
        addv(1, S_HOLD, 32'h33, 1, 2'd2, 0, 32'h0,  0, 2'd0, 3, 2, 1);
        addv(0, S_ILL,  32'h44, 1, 2'd2, 0, 32'h44, 1, 2'd2, 3, 2, 1);
        addv(1, S_BUB,  32'h45, 1, 2'd3, 0, 32'h0,  0, 2'd0, 3, 2, 2);
        addv(0, 6'b000011, 32'h55, 1, 2'd1, 0, 32'h55, 1, 2'd1, 3, 2, 2);
        addv(0, 6'b110000, 32'h66, 0, 2'd3, 0, 32'h66, 0, 2'd3, 3, 2, 2);
        addv(0, S_NONE, 32'h5,  1, 2'd0, 1, 32'h5,  1, 2'd0, 0, 0, 0);
        // Saturation of every counter, clear during hold, clear beating increment
        for (int i = 0; i < 10; i++)
            addv(0, S_HOLD, 32'h9, 1, 2'd3, 0, 32'h5, 1, 2'd0, sat7(i + 1), 0, 0);
        addv(0, S_HOLD, 32'h9, 1, 2'd3, 1, 32'h5, 1, 2'd0, 0, 0, 0);
        addv(0, S_HOLD, 32'h9, 1, 2'd3, 0, 32'h5, 1, 2'd0, 1, 0, 0);
        for (int i = 0; i < 9; i++)
            addv(0, S_BUB, 32'h9, 1, 2'd3, 0, 32'h0, 0, 2'd0, 1, sat7(i + 1), 0);
        for (int i = 0; i < 9; i++)
            addv(1, S_NONE, 32'h9, 1, 2'd3, 0, 32'h0, 0, 2'd0, 1, 7, sat7(i + 1));
        addv(1, S_HOLD, 32'h9, 1, 2'd3, 1, 32'h0, 0, 2'd0, 0, 0, 0);
        addv(0, S_BUB,  32'h9, 1, 2'd3, 0, 32'h0, 0, 2'd0, 0, 1, 0);

        // Reset state before any clock edge
        rst = 1'b1; in_data = 32'hDEADBEEF; in_valid = 1'b1; in_fb = 2'd3;
        stall = S_NONE; flush = 1'b0; cnt_clr = 1'b0;
        #1;
        check_all("reset", 32'h0, 1'b0, 2'd0, 0, 0, 0);
        @(posedge clk); #1;
        check_all("reset_held", 32'h0, 1'b0, 2'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            flush   = vecs[i].flush;
            stall   = vecs[i].stall;
            in_data = vecs[i].d;
            in_valid = vecs[i].v;
            in_fb   = vecs[i].fb;
            cnt_clr = vecs[i].clr;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ev, vecs[i].efb,
                      vecs[i].eh, vecs[i].eb, vecs[i].ef);
            @(negedge clk);
        end

        // Load, show inputs do not reach outputs combinationally, then async reset mid-cycle
        flush = 1'b0; cnt_clr = 1'b0; stall = S_NONE;
        in_data = 32'hDEADBEEF; in_valid = 1'b1; in_fb = 2'd2;
        @(posedge clk); #1;
        check_all("preload", 32'hDEADBEEF, 1'b1, 2'd2, 0, 1, 0);
        in_data = 32'h12345678; in_valid = 1'b0; in_fb = 2'd1; flush = 1'b1;
        #1;
        check("no_comb.data",  64'(out_data),  64'hDEADBEEF);
        check("no_comb.valid", 64'(out_valid), 64'd1);
        in_data = 32'hDEADBEEF; in_valid = 1'b1; in_fb = 2'd2; flush = 1'b0;
        rst = 1'b1;
        #1;
        check_all("async_rst", 32'h0, 1'b0, 2'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("rst_release_noedge", 32'h0, 1'b0, 2'd0, 0, 0, 0);
        @(posedge clk); #1;
        check_all("after_release", 32'hDEADBEEF, 1'b1, 2'd2, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
